// File: rtl/register_file.sv
// Eight-entry register file for the tiny16 CPU: r0 is the PC, r1 the link register, r7 the ALU temp.
// Reads are combinational from the flops; writes and the PC increment land on the rising edge.
module register_file #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       reg_src_sel,
    input  logic [2:0]       reg_dst_sel,
    input  logic             reg_in_en,
    input  logic             reg_out_en,
    input  logic             reg_pc_inc,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_out_en,
    output logic [WIDTH-1:0] pc,
    input  logic [2:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 3;

    logic [WIDTH-1:0] regs [NUM_REGS];

    // The write is assigned last so a same-edge write to r0 overrides the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs[0] <= PC_RESET;
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[SEL_W'(i)] <= '0;
            end
        end else begin
            if (reg_pc_inc) begin
                regs[0] <= regs[0] + WIDTH'(1);
            end
            if (reg_in_en) begin
                regs[reg_dst_sel] <= bus_in;
            end
        end
    end

    // Read ports see the pre-edge contents; no write-through bypass.
    always_comb begin
        bus_out    = reg_out_en ? regs[reg_src_sel] : '0;
        bus_out_en = reg_out_en;
        pc         = regs[0];
        dbg_data   = regs[dbg_sel];
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a randomized run
// against an array-based reference model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  reg_src_sel;
    logic [2:0]  reg_dst_sel;
    logic        reg_in_en;
    logic        reg_out_en;
    logic        reg_pc_inc;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_out_en;
    logic [15:0] pc;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_data;

    int checks   = 0;
    int failures = 0;

    logic [15:0] model [8];

    register_file #(
        .WIDTH    (16),
        .PC_RESET (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_src_sel (reg_src_sel),
        .reg_dst_sel (reg_dst_sel),
        .reg_in_en   (reg_in_en),
        .reg_out_en  (reg_out_en),
        .reg_pc_inc  (reg_pc_inc),
        .bus_in      (bus_in),
        .bus_out     (bus_out),
        .bus_out_en  (bus_out_en),
        .pc          (pc),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        model[0] = 16'h0000;
        for (int i = 1; i < 8; i++) model[i] = 16'h0000;
    endfunction

    // Next state from the architectural rules: a write to r0 beats the increment.
    function automatic void model_edge(input logic [2:0] dst, input logic we, input logic inc,
                                       input logic [15:0] din);
        int next_pc;
        next_pc = (int'(model[0]) + (inc ? 1 : 0)) % 65536;
        if (we) model[dst] = din;
        if (!(we && dst == 3'd0)) model[0] = 16'(next_pc);
    endfunction

    task automatic drive(input logic [2:0] src, input logic [2:0] dst, input logic we,
                         input logic oe, input logic inc, input logic [15:0] din);
        @(negedge clk);
        reg_src_sel = src;
        reg_dst_sel = dst;
        reg_in_en   = we;
        reg_out_en  = oe;
        reg_pc_inc  = inc;
        bus_in      = din;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] dst, input logic [15:0] val);
        drive(3'd0, dst, 1'b1, 1'b0, 1'b0, val);
        tick();
        model_edge(dst, 1'b1, 1'b0, val);
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        reg_src_sel = 3'd0; reg_dst_sel = 3'd0; reg_in_en = 1'b0; reg_out_en = 1'b0;
        reg_pc_inc = 1'b0; bus_in = 16'h0000; dbg_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (pc !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 16'h0000); end
        checks++;
        if (bus_out !== 16'h0000 || bus_out_en !== 1'b0) begin
            failures++; $display("FAIL reset_bus got=%h/%b exp=0000/0", bus_out, bus_out_en);
        end
        dbg_sel = 3'd3; #1;
        checks++;
        if (dbg_data !== 16'h0000) begin failures++; $display("FAIL reset_dbg got=%h exp=0000", dbg_data); end
        @(negedge clk);
        rst = 1'b0;
        write_reg(3'd0, 16'h1234);
        write_reg(3'd5, 16'hBEEF);
        dbg_sel = 3'd5; #1;
        checks++;
        if (pc !== 16'h1234 || dbg_data !== 16'hBEEF) begin
            failures++; $display("FAIL preload got pc=%h r5=%h exp 1234/beef", pc, dbg_data);
        end
        // Asynchronous pulse between edges, with a write pending to r5.
        reg_in_en = 1'b1; reg_dst_sel = 3'd5; bus_in = 16'h7777;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pc !== 16'h0000 || dbg_data !== 16'h0000) begin
            failures++; $display("FAIL async_reset got pc=%h r5=%h exp 0000/0000", pc, dbg_data);
        end
        reg_in_en = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (dbg_data !== 16'h0000) begin failures++; $display("FAIL pending_write_lost got=%h exp=0000", dbg_data); end
    endtask

    task automatic test_write_read();
        write_reg(3'd3, 16'hA5A5);
        drive(3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000);
        #1;
        checks++;
        if (bus_out !== 16'hA5A5 || bus_out_en !== 1'b1) begin
            failures++; $display("FAIL readback got=%h/%b exp=a5a5/1", bus_out, bus_out_en);
        end
        reg_out_en = 1'b0;
        #1;
        checks++;
        if (bus_out !== 16'h0000 || bus_out_en !== 1'b0) begin
            failures++; $display("FAIL read_disabled got=%h/%b exp=0000/0", bus_out, bus_out_en);
        end
    endtask

    task automatic test_pc_wrap();
        write_reg(3'd0, 16'hFFFE);
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        model_edge(3'd0, 1'b0, 1'b1, 16'h0000);
        checks++;
        if (pc !== 16'hFFFF || pc !== model[0]) begin failures++; $display("FAIL pc_inc got=%h exp=ffff", pc); end
        tick();
        model_edge(3'd0, 1'b0, 1'b1, 16'h0000);
        checks++;
        if (pc !== 16'h0000 || pc !== model[0]) begin failures++; $display("FAIL pc_wrap got=%h exp=0000", pc); end
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_conflict();
        write_reg(3'd0, 16'h0010);
        drive(3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0200);
        tick();
        model_edge(3'd0, 1'b1, 1'b1, 16'h0200);
        checks++;
        if (pc !== 16'h0200) begin failures++; $display("FAIL conflict_r0 got=%h exp=0200", pc); end
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        write_reg(3'd0, 16'h0010);
        drive(3'd0, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0200);
        tick();
        model_edge(3'd2, 1'b1, 1'b1, 16'h0200);
        dbg_sel = 3'd2; #1;
        checks++;
        if (pc !== 16'h0011 || dbg_data !== 16'h0200) begin
            failures++; $display("FAIL conflict_r2 got pc=%h r2=%h exp 0011/0200", pc, dbg_data);
        end
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_move();
        write_reg(3'd0, 16'h0040);
        drive(3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0000);
        #1 bus_in = bus_out;
        #1;
        checks++;
        if (bus_out !== 16'h0040) begin failures++; $display("FAIL move_read got=%h exp=0040", bus_out); end
        tick();
        model_edge(3'd1, 1'b1, 1'b0, 16'h0040);
        dbg_sel = 3'd1; #1;
        checks++;
        if (dbg_data !== 16'h0040) begin failures++; $display("FAIL jsr_link got=%h exp=0040", dbg_data); end
        write_reg(3'd4, 16'h5A5A);
        drive(3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 16'h0000);
        #1 bus_in = bus_out;
        tick();
        dbg_sel = 3'd4; #1;
        checks++;
        if (dbg_data !== 16'h5A5A) begin failures++; $display("FAIL self_move got=%h exp=5a5a", dbg_data); end
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_random();
        logic [2:0]  src, dst;
        logic        we, oe, inc;
        logic [15:0] din, exp_bus;
        for (int n = 0; n < 1000; n++) begin
            src = 3'($urandom_range(0, 7));
            dst = 3'($urandom_range(0, 7));
            we  = 1'($urandom_range(0, 1));
            oe  = 1'($urandom_range(0, 1));
            inc = 1'($urandom_range(0, 1));
            din = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            drive(src, dst, we, oe, inc, din);
            dbg_sel = 3'($urandom_range(0, 7));
            #1;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                checks++;
                if (pc !== model[0] || dbg_data !== model[dbg_sel]) begin
                    failures++; $display("FAIL rand_reset n=%0d got pc=%h dbg=%h exp %h/%h", n, pc, dbg_data, model[0], model[dbg_sel]);
                end
                rst = 1'b0;
                #1;
            end
            exp_bus = oe ? model[src] : 16'h0000;
            checks++;
            if (bus_out !== exp_bus || bus_out_en !== oe || dbg_data !== model[dbg_sel]) begin
                failures++;
                $display("FAIL rand_read n=%0d got bus=%h en=%b dbg=%h exp %h/%b/%h", n, bus_out, bus_out_en, dbg_data, exp_bus, oe, model[dbg_sel]);
            end
            tick();
            model_edge(dst, we, inc, din);
            checks++;
            if (pc !== model[0] || dbg_data !== model[dbg_sel]) begin
                failures++; $display("FAIL rand_update n=%0d got pc=%h dbg=%h exp %h/%h", n, pc, dbg_data, model[0], model[dbg_sel]);
            end
        end
        drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_pc_wrap();
        test_conflict();
        test_move();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Eight-entry, 16-bit register file sitting directly downstream of the instruction-sequencing controller in the tiny16 CPU. It consumes the controller's `reg_*` control signals and exchanges data with the shared data bus. Register 0 is the program counter, register 1 is the link register written by JSR, and register 7 is the ALU operand temp used by immediate and indirect operations. All state updates happen on the rising clock edge, so values driven by the controller on the falling edge are captured half a cycle later.

## Interface
- `WIDTH`, 16, data width of every register and of the bus
- `PC_RESET`, 16'h0000, value loaded into r0 (PC) on reset
- `clk`  input  1  system clock; all state changes on posedge
- `rst`  input  1  reset, asynchronous, active-high; clears all registers
- `reg_src_sel`  input  3  register driven onto `bus_out` when `reg_out_en`=1
- `reg_dst_sel`  input  3  register written from `bus_in` when `reg_in_en`=1
- `reg_in_en`  input  1  write strobe, sampled at posedge
- `reg_out_en`  input  1  read enable for `bus_out`
- `reg_pc_inc`  input  1  increment r0 at posedge
- `bus_in`  input  WIDTH  data from the bus (memory, ALU or controller immediate)
- `bus_out`  output  WIDTH  `regs[reg_src_sel]` when `reg_out_en`=1, else 0
- `bus_out_en`  output  1  copy of `reg_out_en`; the bus mux selects this source when high
- `pc`  output  WIDTH  current r0, always valid
- `dbg_sel`  input  3  debug read-port select
- `dbg_data`  output  WIDTH  `regs[dbg_sel]`, combinational

## Operation
- Storage: 8 x WIDTH flops, r0..r7. No reserved zero register.
- Reset (async assert, any time): r0 <= `PC_RESET`, r1..r7 <= 0. While `rst`=1 all writes and increments are ignored. Deassertion is sampled synchronously; the first update happens at the first posedge with `rst`=0.
- Write: at posedge with `reg_in_en`=1, `regs[reg_dst_sel]` <= `bus_in`.
- PC increment: at posedge with `reg_pc_inc`=1, r0 <= r0 + 1, modulo 2^WIDTH (16'hFFFF -> 16'h0000, no flag).
- Same-edge conflict: when `reg_in_en`=1 with `reg_dst_sel`=0 and `reg_pc_inc`=1, the write wins and the increment is dropped. When `reg_dst_sel`!=0, both the write and the increment take effect.
- Read: `bus_out` and `dbg_data` are combinational from the flop contents. A read in the same cycle as a write to the same register returns the old value; there is no write-through bypass.
- Moves: `reg_out_en`=1 and `reg_in_en`=1 with src=dst is a legal no-op (value unchanged). The controller's register-to-register LD relies on src!=dst working in a single cycle: the old src value is written to dst at the edge.
- Outputs `bus_out`, `bus_out_en`, `dbg_data` and `pc` carry no X. `bus_out` is forced to 0 when `reg_out_en`=0. The block has no tri-state drivers.

## Timing
- Write latency: one posedge. The new value is visible on `bus_out`/`pc`/`dbg_data` immediately after that edge.
- Read latency: zero cycles (combinational).
- Reset values: `pc`=`PC_RESET`, `bus_out`=0, `bus_out_en`=0 (follows input), `dbg_data`=0 unless `dbg_sel`=0, in which case it shows `PC_RESET`.
- Fetch sequence as driven by the controller: step 0 reads r0 onto the bus; step 1 asserts `reg_pc_inc`, so r0 increments at the step-1 posedge; a JMP/JSR in step 3/4 writes r0 and overrides the incremented value.
- JSR: at step 3, r0 is read and r1 is written in one cycle, giving r1 = return address. At step 4, r0 <= target.
- Reset asserted mid-instruction: all registers take reset values immediately, without waiting for a clock edge, and any pending write is lost.

## Test plan
- Reset: preload r0=16'h1234 and r5=16'hBEEF, pulse `rst` between clock edges -> `pc`=16'h0000 and `dbg_data`(sel 5)=0 before the next posedge.
- Write/readback: `bus_in`=16'hA5A5, dst=3, `reg_in_en` for 1 cycle; then src=3, `reg_out_en` -> `bus_out`=16'hA5A5 and `bus_out_en`=1; with `reg_out_en`=0 -> `bus_out`=0.
- PC wrap: write r0=16'hFFFE, assert `reg_pc_inc` for 2 cycles -> `pc` 16'hFFFF then 16'h0000.
- Conflict: r0=16'h0010, same edge: `reg_pc_inc`=1, `reg_in_en`=1, dst=0, `bus_in`=16'h0200 -> `pc`=16'h0200. Repeat with dst=2 -> `pc`=16'h0011 and r2=16'h0200.
- Read-during-write and JSR move: r0=16'h0040, src=0, dst=1, `reg_out_en`=`reg_in_en`=1, `bus_in` looped from `bus_out` -> during the cycle `bus_out`=16'h0040; after the edge r1=16'h0040.
- Random sequence of 1000 write/inc/read cycles checked against a reference model, including mid-sequence resets.
